ut_param: RTL
=============

# ut_param

Parametrised processing unit (UT) datapath: an accumulator, a small register file, carry and zero flags, an 8-operation ALU, and a multi-cycle shift-add multiplier. It sits under the Tiny Tapeout top level and is driven each cycle by control lines from the pad inputs or a future sequencer. It generalises the fixed 8-bit single-register UT in data width and register count, and adds a zero flag and a multiply sequencer with a busy/done handshake.

## Interface
Parameters:
- WIDTH, 8: datapath width in bits, ≥ 2.
- NREG, 4: register-file depth, power of 2, ≥ 2. ADDR_W = clog2(NREG) is derived.

Ports:
- clk  in  1  single clock; all state updates on the rising edge.
- rst  in  1  synchronous, active-high reset; overrides everything, including ce.
- ce  in  1  clock enable; 0 freezes all state, including the multiplier step counter.
- sel_ual  in  3  ALU operation select.
- reg_sel  in  ADDR_W  register-file index, used for operand B, for writes and as the multiply high-word destination.
- src_sel  in  1  1: B = data_in; 0: B = reg[reg_sel].
- data_in  in  WIDTH  external operand.
- load_reg  in  1  reg[reg_sel] <= (src_sel ? data_in : accu).
- load_accu  in  1  accu <= ALU result; zero flag updated.
- load_carry  in  1  carry <= ALU carry-out.
- init_carry  in  1  carry <= 0; has priority over load_carry.
- start_mul  in  1  start multiply accu × B.
- busy  out  1  multiply in progress.
- done  out  1  one-cycle pulse; multiply result written.
- carry  out  1  carry register.
- zero  out  1  zero flag register.
- data_out  out  WIDTH  accumulator value, registered.

## Operation
- A = accu. ALU carry-in is the carry register. Results are truncated to WIDTH bits.
- sel_ual operations:
  - 000: res = B, cout = 0.
  - 001: A+B, cout = bit WIDTH of the sum.
  - 010: A+B+carry, cout = bit WIDTH.
  - 011: A−B, cout = 1 iff A < B (borrow).
  - 100: A&B, cout = 0.
  - 101: A|B, cout = 0.
  - 110: A^B, cout = 0.
  - 111: {A[W-2:0], carry}, cout = A[W-1].
- load_reg, load_accu and load_carry/init_carry may all be asserted in one cycle. Each uses pre-edge values. load_reg with src_sel=0 stores the old accu.
- zero <= (ALU result == 0) only when load_accu=1. Otherwise zero holds.
- Multiply FSM, states IDLE and RUN:
  - IDLE→RUN on start_mul=1 with ce=1. Latch multiplicand = accu, multiplier = B and dest = reg_sel. Clear the 2·WIDTH product and the step counter.
  - RUN performs one shift-add step per ce=1 cycle, WIDTH steps total, unsigned.
  - The last step returns to IDLE and writes accu = product[W-1:0] and reg[dest] = product[2W-1:W]. It also sets carry = 0, zero = (product == 0), and done = 1.
- In the start cycle and throughout RUN, load_reg, load_accu, load_carry, init_carry and start_mul are ignored. start_mul outranks the loads in its own cycle.
- Reset values:
  - accu, all reg[] entries, carry, busy, done: 0.
  - zero: 1.
  - FSM: IDLE.
- rst during RUN aborts the multiply. No partial result is written, and all reset values are seen the next cycle.

## Timing
- Loads: the result is visible on outputs the cycle after the sampling edge (1-cycle latency).
- Multiply: start is sampled at edge k. busy=1 for exactly WIDTH ce-enabled cycles after k. The results, done=1 and busy=0 all appear together in the first cycle following the last step.
  - With ce held at 1: busy is high from cycle k+1 through k+WIDTH, and done is high in cycle k+WIDTH+1 only.
- ce=0 stretches busy. done stays registered and held while ce=0, and clears on the next ce=1 edge.
- done and busy are never high together.
- A new start_mul is accepted in the same cycle that done=1.

## Test plan
- Reset: assert rst 2 cycles with random inputs. Expect data_out=0x00, carry=0, zero=1, busy=0 and done=0; expect all registers 0 when read via op 000 with src_sel=0.
- Add/carry, WIDTH=8:
  - Load accu=0xF0 (op 000, src_sel=1).
  - Op 001 with B=0x20, load_accu and load_carry: expect accu=0x10, carry=1, zero=0.
  - Op 010 with B=0x00: expect accu=0x11, carry=0.
  - Assert init_carry and load_carry together: expect carry=0.
- Subtract:
  - accu=0x05, op 011 with B=0x07: expect accu=0xFE, carry=1.
  - Reload 0x05, op 011 with B=0x05: expect accu=0x00, carry=0, zero=1.
- Register file:
  - load_reg with reg_sel=2, src_sel=1, data_in=0x3C.
  - accu=0xFF, op 110 with src_sel=0, reg_sel=2: expect accu=0xC3.
  - Confirm reg1 and reg3 are unchanged (0x00).
- Multiply:
  - accu=0xFF, B=0xFF (data_in), reg_sel=1, start_mul.
  - Expect busy high for 8 cycles, then done for 1 cycle, accu=0x01, reg1=0xFE, carry=0, zero=0.
  - load_accu with data_in=0xAA pulsed during busy has no effect.
- ce and reset during multiply:
  - Repeat the multiply with ce=0 for 3 cycles mid-run: expect busy lasting 11 cycles and the identical result.
  - Repeat with rst at step 4: expect accu=0, reg1=0, busy=0 and no done pulse.

Source files
------------

// File: rtl/ut_param.sv
// ut_param: parametrised processing-unit datapath.
// Accumulator, small register file, carry/zero flags, an 8-operation ALU
// and a multi-cycle unsigned shift-add multiplier with busy/done handshake.
// All state is synchronous to clk_i; rst_i is synchronous and active-high,
// and ce_i = 0 freezes every register in the block.
module ut_param #(
  parameter int WIDTH  = 8,
  parameter int NREG   = 4,
  localparam int ADDR_W = $clog2(NREG)
) (
  input  logic              clk_i,
  input  logic              rst_i,
  input  logic              ce_i,
  input  logic [2:0]        sel_ual_i,
  input  logic [ADDR_W-1:0] reg_sel_i,
  input  logic              src_sel_i,
  input  logic [WIDTH-1:0]  data_in_i,
  input  logic              load_reg_i,
  input  logic              load_accu_i,
  input  logic              load_carry_i,
  input  logic              init_carry_i,
  input  logic              start_mul_i,
  output logic              busy_o,
  output logic              done_o,
  output logic              carry_o,
  output logic              zero_o,
  output logic [WIDTH-1:0]  data_out_o
);

  // Step counter must hold values 0 .. WIDTH-1.
  localparam int CNT_W = $clog2(WIDTH + 1);

  localparam logic [2:0] OP_PASS = 3'b000;
  localparam logic [2:0] OP_ADD  = 3'b001;
  localparam logic [2:0] OP_ADC  = 3'b010;
  localparam logic [2:0] OP_SUB  = 3'b011;
  localparam logic [2:0] OP_AND  = 3'b100;
  localparam logic [2:0] OP_OR   = 3'b101;
  localparam logic [2:0] OP_XOR  = 3'b110;
  localparam logic [2:0] OP_RLC  = 3'b111;

  typedef enum logic [0:0] {
    ST_IDLE = 1'b0,
    ST_RUN  = 1'b1
  } state_e;

  // ALU: returns {carry_out, result}. Subtract computes on WIDTH+1 bits so
  // the top bit of the difference is exactly the borrow (A < B).
  function automatic logic [WIDTH:0] alu_f(
    input logic [2:0]       op,
    input logic [WIDTH-1:0] a,
    input logic [WIDTH-1:0] b,
    input logic             cin
  );
    logic [WIDTH:0] r;
    r = '0;
    case (op)
      OP_PASS: r = {1'b0, b};
      OP_ADD:  r = {1'b0, a} + {1'b0, b};
      OP_ADC:  r = {1'b0, a} + {1'b0, b} + {{WIDTH{1'b0}}, cin};
      OP_SUB:  r = {1'b0, a} - {1'b0, b};
      OP_AND:  r = {1'b0, a & b};
      OP_OR:   r = {1'b0, a | b};
      OP_XOR:  r = {1'b0, a ^ b};
      OP_RLC:  r = {a[WIDTH-1], a[WIDTH-2:0], cin};
      default: r = '0;
    endcase
    return r;
  endfunction

  // Architectural state
  state_e                  state_q, state_d;
  logic [WIDTH-1:0]        accu_q,  accu_d;
  logic                    carry_q, carry_d;
  logic                    zero_q,  zero_d;
  logic                    busy_q,  busy_d;
  logic                    done_q,  done_d;
  logic [WIDTH-1:0]        regs_q [NREG];

  // Multiplier working state. The low product half shares the multiplier
  // register: each step shifts a product bit in from the top as a
  // multiplier bit is consumed from the bottom.
  logic [WIDTH-1:0]        mcand_q, mcand_d;
  logic [WIDTH-1:0]        prod_hi_q, prod_hi_d;
  logic [WIDTH-1:0]        prod_lo_q, prod_lo_d;
  logic [ADDR_W-1:0]       dest_q,  dest_d;
  logic [CNT_W-1:0]        cnt_q,   cnt_d;

  // Combinational helpers
  logic [WIDTH-1:0]        b_s;
  logic [WIDTH:0]          alu_s;
  logic                    idle_s;
  logic                    run_s;
  logic                    last_s;
  logic [WIDTH:0]          partial_s;
  logic [2*WIDTH-1:0]      prod_step_s;
  logic                    rf_we_s;
  logic [ADDR_W-1:0]       rf_addr_s;
  logic [WIDTH-1:0]        rf_wdata_s;

  // Operand select, ALU evaluation and one shift-add multiplier step.
  always_comb begin
    b_s         = src_sel_i ? data_in_i : regs_q[reg_sel_i];
    alu_s       = alu_f(sel_ual_i, accu_q, b_s, carry_q);
    idle_s      = (state_q == ST_IDLE);
    run_s       = (state_q == ST_RUN);
    last_s      = run_s && (cnt_q == CNT_W'(WIDTH - 1));
    partial_s   = {1'b0, prod_hi_q} + (prod_lo_q[0] ? {1'b0, mcand_q} : {(WIDTH+1){1'b0}});
    prod_step_s = {partial_s, prod_lo_q[WIDTH-1:1]};
  end

  // FSM state register.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q <= ST_IDLE;
    end else if (ce_i) begin
      state_q <= state_d;
    end else begin
      state_q <= state_q;
    end
  end

  // FSM next-state: IDLE -> RUN on start, RUN -> IDLE after the last step.
  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_IDLE: begin
        if (start_mul_i) begin
          state_d = ST_RUN;
        end else begin
          state_d = ST_IDLE;
        end
      end
      ST_RUN: begin
        if (last_s) begin
          state_d = ST_IDLE;
        end else begin
          state_d = ST_RUN;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  // FSM outputs: busy follows the upcoming state, done marks the final step.
  always_comb begin
    busy_d = (state_d == ST_RUN);
    done_d = last_s;
  end

  // Handshake output registers; done is held while ce is low.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      busy_q <= 1'b0;
      done_q <= 1'b0;
    end else if (ce_i) begin
      busy_q <= busy_d;
      done_q <= done_d;
    end else begin
      busy_q <= busy_q;
      done_q <= done_q;
    end
  end

  // Datapath next-state: multiply sequencing has priority, the start cycle
  // blocks all loads, otherwise the individual load strobes apply.
  always_comb begin
    accu_d     = accu_q;
    carry_d    = carry_q;
    zero_d     = zero_q;
    mcand_d    = mcand_q;
    prod_hi_d  = prod_hi_q;
    prod_lo_d  = prod_lo_q;
    dest_d     = dest_q;
    cnt_d      = cnt_q;
    rf_we_s    = 1'b0;
    rf_addr_s  = reg_sel_i;
    rf_wdata_s = src_sel_i ? data_in_i : accu_q;

    if (run_s) begin
      prod_hi_d = prod_step_s[2*WIDTH-1:WIDTH];
      prod_lo_d = prod_step_s[WIDTH-1:0];
      cnt_d     = cnt_q + CNT_W'(1);
      if (last_s) begin
        accu_d     = prod_step_s[WIDTH-1:0];
        carry_d    = 1'b0;
        zero_d     = (prod_step_s == {(2*WIDTH){1'b0}});
        rf_we_s    = 1'b1;
        rf_addr_s  = dest_q;
        rf_wdata_s = prod_step_s[2*WIDTH-1:WIDTH];
      end else begin
        rf_we_s    = 1'b0;
      end
    end else if (idle_s && start_mul_i) begin
      mcand_d   = accu_q;
      prod_lo_d = b_s;
      prod_hi_d = '0;
      dest_d    = reg_sel_i;
      cnt_d     = '0;
    end else begin
      if (load_reg_i) begin
        rf_we_s = 1'b1;
      end else begin
        rf_we_s = 1'b0;
      end
      if (load_accu_i) begin
        accu_d = alu_s[WIDTH-1:0];
        zero_d = (alu_s[WIDTH-1:0] == {WIDTH{1'b0}});
      end else begin
        accu_d = accu_q;
      end
      if (init_carry_i) begin
        carry_d = 1'b0;
      end else if (load_carry_i) begin
        carry_d = alu_s[WIDTH];
      end else begin
        carry_d = carry_q;
      end
    end
  end

  // Accumulator, flags and multiplier working registers.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      accu_q    <= '0;
      carry_q   <= 1'b0;
      zero_q    <= 1'b1;
      mcand_q   <= '0;
      prod_hi_q <= '0;
      prod_lo_q <= '0;
      dest_q    <= '0;
      cnt_q     <= '0;
    end else if (ce_i) begin
      accu_q    <= accu_d;
      carry_q   <= carry_d;
      zero_q    <= zero_d;
      mcand_q   <= mcand_d;
      prod_hi_q <= prod_hi_d;
      prod_lo_q <= prod_lo_d;
      dest_q    <= dest_d;
      cnt_q     <= cnt_d;
    end else begin
      accu_q    <= accu_q;
      carry_q   <= carry_q;
      zero_q    <= zero_q;
      mcand_q   <= mcand_q;
      prod_hi_q <= prod_hi_q;
      prod_lo_q <= prod_lo_q;
      dest_q    <= dest_q;
      cnt_q     <= cnt_q;
    end
  end

  // Register file: single write port shared by load_reg and the multiply
  // high-word write-back.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      for (int i = 0; i < NREG; i++) begin
        regs_q[i] <= '0;
      end
    end else if (ce_i && rf_we_s) begin
      regs_q[rf_addr_s] <= rf_wdata_s;
    end
  end

  assign busy_o     = busy_q;
  assign done_o     = done_q;
  assign carry_o    = carry_q;
  assign zero_o     = zero_q;
  assign data_out_o = accu_q;

endmodule
